// File: rtl/decoder_glue_pkg.sv
// Shared constants and types for the RV32I decoder glue.
// Holds the opcode values, the immediate-format / ALU-class / write-back
// encodings and the packed control bundle that the decode case fills in.
package decoder_glue_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd5
   } imm_src_e;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_FUNCT  = 2'b10,
      ALU_PASS   = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   // Field order matches the decode table: regWrite, ALUSrc, MemRead,
   // MemWrite, BranchSig, Jump, ALUOp, wb_sel, ImmSrc.
   typedef struct packed {
      logic     reg_write;
      logic     alu_src;
      logic     mem_read;
      logic     mem_write;
      logic     branch;
      logic     jump;
      alu_op_e  alu_op;
      wb_sel_e  wb_sel;
      imm_src_e imm_src;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   ALU_ADD, WB_ALU, IMM_NONE};

endpackage

// File: rtl/decoder_glue_if.sv
// Decoder bus: instruction word in, register indices, immediate and control
// strobes out. master = instruction source, slave = decoder.
interface decoder_glue_if;
   logic [31:0] instr;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        regWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        ALUSrc;
   logic        BranchSig;
   logic        Jump;
   logic        JAL;
   logic        JALR;
   logic        Branch;
   logic [1:0]  ALUOp;
   logic [2:0]  ImmSrc;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic        illegal_seen;

   modport master (
      output instr,
      input  rd, rs1, rs2, imm, regWrite, MemRead, MemWrite, ALUSrc,
             BranchSig, Jump, JAL, JALR, Branch, ALUOp, ImmSrc, wb_sel,
             illegal, illegal_seen
   );

   modport slave (
      input  instr,
      output rd, rs1, rs2, imm, regWrite, MemRead, MemWrite, ALUSrc,
             BranchSig, Jump, JAL, JALR, Branch, ALUOp, ImmSrc, wb_sel,
             illegal, illegal_seen
   );
endinterface

// File: rtl/decoder_glue_imm_gen.sv
// Immediate generator (imm_gen): forms the 32-bit immediate for the selected
// RV32I format.
//   instr   : instruction bits [31:7] (the opcode never contributes)
//   imm_src : immediate format select
//   imm     : formed immediate, 0 for IMM_NONE and any unused code
module decoder_glue_imm_gen
   import decoder_glue_pkg::*;
(
   input  logic [31:7] instr,
   input  imm_src_e    imm_src,
   output logic [31:0] imm
);

   always_comb begin
      imm = 32'd0;
      case (imm_src)
         IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
         IMM_U: imm = {instr[31:12], 12'd0};
         IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                       instr[20], instr[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
   end

endmodule

// File: rtl/decoder_glue.sv
// RV32I decode glue: slices register fields, decodes the opcode into control
// strobes, forms the immediate and keeps a sticky illegal-opcode flag.
//   clk : rising-edge clock (only the sticky flag is clocked)
//   rst : asynchronous active-high reset, clears illegal_seen only
//   bus : decoder_glue_if.slave, instr in, everything else out
module decoder_glue
   import decoder_glue_pkg::*;
(
   input logic          clk,
   input logic          rst,
   decoder_glue_if.slave bus
);

   ctrl_t      ctrl;
   logic       illegal;
   logic       illegal_seen_q;
   logic [6:0] opcode;

   assign opcode  = bus.instr[6:0];

   assign bus.rd  = bus.instr[11:7];
   assign bus.rs1 = bus.instr[19:15];
   assign bus.rs2 = bus.instr[24:20];

   // funct3/funct7 are deliberately ignored: ALU-level decode is downstream.
   always_comb begin
      ctrl    = CTRL_NONE;
      illegal = 1'b0;
      case (opcode)
         OP_R:      ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_FUNCT,  WB_ALU, IMM_NONE};
         OP_IALU:   ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_FUNCT,  WB_ALU, IMM_I};
         OP_LOAD:   ctrl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD,    WB_MEM, IMM_I};
         OP_STORE:  ctrl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD,    WB_ALU, IMM_S};
         OP_BRANCH: ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_BRANCH, WB_ALU, IMM_B};
         OP_JAL:    ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD,    WB_PC4, IMM_J};
         OP_JALR:   ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD,    WB_PC4, IMM_I};
         OP_LUI:    ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_PASS,   WB_ALU, IMM_U};
         OP_AUIPC:  ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD,    WB_ALU, IMM_U};
         default: begin
            ctrl    = CTRL_NONE;
            illegal = 1'b1;
         end
      endcase
   end

   assign bus.regWrite  = ctrl.reg_write;
   assign bus.ALUSrc    = ctrl.alu_src;
   assign bus.MemRead   = ctrl.mem_read;
   assign bus.MemWrite  = ctrl.mem_write;
   assign bus.BranchSig = ctrl.branch;
   assign bus.Branch    = ctrl.branch;
   assign bus.Jump      = ctrl.jump;
   assign bus.JAL       = (opcode == OP_JAL);
   assign bus.JALR      = (opcode == OP_JALR);
   assign bus.ALUOp     = ctrl.alu_op;
   assign bus.wb_sel    = ctrl.wb_sel;
   assign bus.ImmSrc    = ctrl.imm_src;
   assign bus.illegal   = illegal;

   decoder_glue_imm_gen u_imm_gen (
      .instr   (bus.instr[31:7]),
      .imm_src (ctrl.imm_src),
      .imm     (bus.imm)
   );

   // Sticky: once an illegal opcode is seen on an edge it stays until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_seen_q <= 1'b0;
      end else if (illegal) begin
         illegal_seen_q <= 1'b1;
      end
   end

   assign bus.illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_decoder_glue.sv
module tb_decoder_glue;
   logic clk;
   logic rst;
   int   errors;
   int   checks;
   logic [31:0] exp_q[$];

   localparam logic [31:0] NOP = 32'h00000013;

   decoder_glue_if bus ();

   decoder_glue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- encoders (assembly -> word) ----------------
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   // ---------------- reference model ----------------
   // Control word layout: rd, rs1, rs2, regWrite, MemRead, MemWrite, ALUSrc,
   // BranchSig, Jump, JAL, JALR, Branch, ALUOp, ImmSrc, wb_sel, illegal.
   function automatic logic [31:0] model_ctl(input logic [31:0] i);
      logic rw, asrc, mr, mw, bs, jp, ill;
      logic [1:0] aop, wb;
      logic [2:0] isrc;
      rw = 0; asrc = 0; mr = 0; mw = 0; bs = 0; jp = 0; ill = 0;
      aop = 0; wb = 0; isrc = 5;
      case (i[6:0])
         7'h33: begin rw = 1; aop = 2; isrc = 5; end
         7'h13: begin rw = 1; asrc = 1; aop = 2; isrc = 0; end
         7'h03: begin rw = 1; asrc = 1; mr = 1; wb = 1; isrc = 0; end
         7'h23: begin asrc = 1; mw = 1; isrc = 1; end
         7'h63: begin bs = 1; aop = 1; isrc = 2; end
         7'h6F: begin rw = 1; asrc = 1; jp = 1; wb = 2; isrc = 4; end
         7'h67: begin rw = 1; asrc = 1; jp = 1; wb = 2; isrc = 0; end
         7'h37: begin rw = 1; asrc = 1; aop = 3; isrc = 3; end
         7'h17: begin rw = 1; asrc = 1; isrc = 3; end
         default: ill = 1;
      endcase
      return {i[11:7], i[19:15], i[24:20], rw, mr, mw, asrc, bs, jp,
              (i[6:0] == 7'h6F), (i[6:0] == 7'h67), bs, aop, isrc, wb, ill};
   endfunction

   // Immediate value computed arithmetically from the ISA field weights.
   function automatic logic [31:0] model_imm(input logic [31:0] i);
      int v;
      v = 0;
      case (i[6:0])
         7'h13, 7'h03, 7'h67:
            v = int'(i[30:20]) - (i[31] ? 2048 : 0);
         7'h23:
            v = int'(i[30:25]) * 32 + int'(i[11:7]) - (i[31] ? 2048 : 0);
         7'h63:
            v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048
                - (i[31] ? 4096 : 0);
         7'h37, 7'h17:
            v = int'(i[31:12]) * 4096;
         7'h6F:
            v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096
                - (i[31] ? (1 << 20) : 0);
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic logic [31:0] dut_ctl();
      return {bus.rd, bus.rs1, bus.rs2, bus.regWrite, bus.MemRead, bus.MemWrite,
              bus.ALUSrc, bus.BranchSig, bus.Jump, bus.JAL, bus.JALR, bus.Branch,
              bus.ALUOp, bus.ImmSrc, bus.wb_sel, bus.illegal};
   endfunction

   function automatic logic [31:0] dut_strobes();
      return {23'd0, bus.regWrite, bus.MemRead, bus.MemWrite, bus.ALUSrc,
              bus.BranchSig, bus.Jump, bus.JAL, bus.JALR, bus.Branch};
   endfunction

   // ---------------- driver ----------------
   task automatic apply(input logic [31:0] word);
      @(negedge clk);
      bus.instr = word;
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0]  legal_ops[9];
      logic [31:0] r;
      logic        seen_model;
      legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.instr = NOP;
      repeat (2) @(posedge clk);
      #1;
      check("reset_seen", 32'(bus.illegal_seen), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // add x5,x1,x2
      apply(32'h002082B3);
      check("add_rd", 32'(bus.rd), 32'd5);
      check("add_rs1", 32'(bus.rs1), 32'd1);
      check("add_rs2", 32'(bus.rs2), 32'd2);
      check("add_regwrite", 32'(bus.regWrite), 32'd1);
      check("add_alusrc", 32'(bus.ALUSrc), 32'd0);
      check("add_aluop", 32'(bus.ALUOp), 32'd2);
      check("add_wbsel", 32'(bus.wb_sel), 32'd0);
      check("add_imm", bus.imm, 32'd0);
      check("add_illegal", 32'(bus.illegal), 32'd0);

      // sub x5,x1,x2: funct7 must not change anything
      apply(32'h402082B3);
      check("sub_ctl", dut_ctl(), model_ctl(32'h002082B3));

      // lw x7,24(x3)
      apply(enc_i(12'd24, 5'd3, 3'd2, 5'd7, 7'h03));
      check("lw_memread", 32'(bus.MemRead), 32'd1);
      check("lw_alusrc", 32'(bus.ALUSrc), 32'd1);
      check("lw_aluop", 32'(bus.ALUOp), 32'd0);
      check("lw_wbsel", 32'(bus.wb_sel), 32'd1);
      check("lw_imm", bus.imm, 32'd24);

      // sw x8,28(x4)
      apply(enc_s(12'd28, 5'd8, 5'd4, 3'd2));
      check("sw_rs1", 32'(bus.rs1), 32'd4);
      check("sw_rs2", 32'(bus.rs2), 32'd8);
      check("sw_memwrite", 32'(bus.MemWrite), 32'd1);
      check("sw_regwrite", 32'(bus.regWrite), 32'd0);
      check("sw_imm", bus.imm, 32'd28);

      // beq x1,x2,+16 and -4
      apply(enc_b(13'd16, 5'd2, 5'd1, 3'd0));
      check("beq_branchsig", 32'(bus.BranchSig), 32'd1);
      check("beq_branch", 32'(bus.Branch), 32'd1);
      check("beq_aluop", 32'(bus.ALUOp), 32'd1);
      check("beq_imm", bus.imm, 32'd16);
      apply(enc_b(13'h1FFC, 5'd2, 5'd1, 3'd0));
      check("beq_neg_imm", bus.imm, 32'hFFFFFFFC);

      // jal x1,+32 ; jalr x5,20(x9)
      apply(enc_j(21'd32, 5'd1));
      check("jal_jump", 32'(bus.Jump), 32'd1);
      check("jal_jal", 32'(bus.JAL), 32'd1);
      check("jal_jalr", 32'(bus.JALR), 32'd0);
      check("jal_wbsel", 32'(bus.wb_sel), 32'd2);
      check("jal_imm", bus.imm, 32'd32);
      apply(enc_i(12'd20, 5'd9, 3'd0, 5'd5, 7'h67));
      check("jalr_jalr", 32'(bus.JALR), 32'd1);
      check("jalr_jal", 32'(bus.JAL), 32'd0);
      check("jalr_imm", bus.imm, 32'd20);

      // lui x10,0x12345 ; auipc x11,0x01234
      apply(enc_u(20'h12345, 5'd10, 7'h37));
      check("lui_aluop", 32'(bus.ALUOp), 32'd3);
      check("lui_imm", bus.imm, 32'h12345000);
      apply(enc_u(20'h01234, 5'd11, 7'h17));
      check("auipc_aluop", 32'(bus.ALUOp), 32'd0);
      check("auipc_imm", bus.imm, 32'h01234000);
      check("legal_seen", 32'(bus.illegal_seen), 32'd0);

      // illegal opcode 0x7F and the sticky flag
      apply(32'h0000007F);
      check("ill_illegal", 32'(bus.illegal), 32'd1);
      check("ill_strobes", dut_strobes(), 32'd0);
      check("ill_aluop", 32'(bus.ALUOp), 32'd0);
      check("ill_wbsel", 32'(bus.wb_sel), 32'd0);
      check("ill_immsrc", 32'(bus.ImmSrc), 32'd5);
      check("ill_imm", bus.imm, 32'd0);
      check("ill_seen_pre", 32'(bus.illegal_seen), 32'd0);
      @(posedge clk);
      #1;
      check("ill_seen_set", 32'(bus.illegal_seen), 32'd1);
      apply(NOP);
      @(posedge clk);
      #1;
      check("ill_seen_sticky", 32'(bus.illegal_seen), 32'd1);

      // asynchronous clear mid-cycle, combinational outputs unaffected by rst
      @(negedge clk);
      bus.instr = 32'h0000007F;
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_clear", 32'(bus.illegal_seen), 32'd0);
      check("rst_comb_illegal", 32'(bus.illegal), 32'd1);
      check("rst_comb_immsrc", 32'(bus.ImmSrc), 32'd5);
      @(posedge clk);
      #1;
      check("rst_held_seen", 32'(bus.illegal_seen), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_seen", 32'(bus.illegal_seen), 32'd0);
      @(posedge clk);
      #1;
      check("rst_next_edge_seen", 32'(bus.illegal_seen), 32'd1);

      // clean start for randomized section
      @(negedge clk);
      bus.instr = NOP;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      check("rand_start_seen", 32'(bus.illegal_seen), 32'd0);

      seen_model = 1'b0;
      for (int n = 0; n < 300; n++) begin
         r = $urandom();
         if ($urandom_range(0, 3) != 0) r[6:0] = legal_ops[$urandom_range(0, 8)];
         apply(r);
         exp_q.push_back(model_ctl(r));
         exp_q.push_back(model_imm(r));
         check("rand_seen", 32'(bus.illegal_seen), 32'(seen_model));
         check("rand_ctl", dut_ctl(), exp_q.pop_front());
         check("rand_imm", bus.imm, exp_q.pop_front());
         if (model_ctl(r) & 32'd1) seen_model = 1'b1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decoder_glue.md
DECODER_GLUE -- requirements
Module: decoder_glue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 async active-high reset.
REQ-002 Port instr SHALL be: input, 32 bits, RV32I instruction word.
REQ-003 Ports rd, rs1, rs2 SHALL be: output, 5 bits each, register indices.
REQ-004 Port imm SHALL be: output, 32 bits, sign/zero-formed immediate.
REQ-005 Ports regWrite, MemRead, MemWrite, ALUSrc, BranchSig, Jump, JAL, JALR, Branch SHALL be: output, 1 bit each, control strobes.
REQ-006 Port ALUOp SHALL be: output, 2 bits, ALU class (00 add, 01 branch compare, 10 funct-decoded, 11 pass-imm/LUI).
REQ-007 Port ImmSrc SHALL be: output, 3 bits, immediate format (0 I, 1 S, 2 B, 3 U, 4 J, 5 none).
REQ-008 Port wb_sel SHALL be: output, 2 bits, write-back source (0 ALU, 1 MEM, 2 PC+4).
REQ-009 Port illegal SHALL be: output, 1 bit, combinational: opcode not in the supported set.
REQ-010 Port illegal_seen SHALL be: output, 1 bit, registered sticky copy of illegal.

Function
REQ-011 All outputs except illegal_seen SHALL be purely combinational from instr, with zero cycle latency.
REQ-012 rd SHALL equal instr[11:7], rs1 SHALL equal instr[19:15], and rs2 SHALL equal instr[24:20] for every opcode.
REQ-013 Control values SHALL be decoded from instr[6:0]; the fields are regWrite, ALUSrc, MemRead, MemWrite, BranchSig, Jump, ALUOp, wb_sel, ImmSrc.
- R 0110011: 1,0,0,0,0,0,10,0,5
- I-ALU 0010011: 1,1,0,0,0,0,10,0,0
- LOAD 0000011: 1,1,1,0,0,0,00,1,0
- STORE 0100011: 0,1,0,1,0,0,00,0,1
- BRANCH 1100011: 0,0,0,0,1,0,01,0,2
- JAL 1101111: 1,1,0,0,0,1,00,2,4
- JALR 1100111: 1,1,0,0,0,1,00,2,0
- LUI 0110111: 1,1,0,0,0,0,11,0,3
- AUIPC 0010111: 1,1,0,0,0,0,00,0,3
REQ-014 JAL SHALL be 1 only for opcode 1101111, JALR SHALL be 1 only for opcode 1100111, and Branch SHALL equal BranchSig.
REQ-015 Any other opcode SHALL drive all strobes 0, ALUOp 00, wb_sel 0, ImmSrc 5, imm 0, and illegal 1.
REQ-016 The I immediate SHALL be sign-extended instr[31:20].
REQ-017 The S immediate SHALL be sign-extended {instr[31:25],instr[11:7]}.
REQ-018 The B immediate SHALL be sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
REQ-019 The U immediate SHALL be {instr[31:12],12'b0}.
REQ-020 The J immediate SHALL be sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
REQ-021 ImmSrc 5 (none) SHALL produce imm = 0.
REQ-022 funct3/funct7 SHALL NOT affect any output of this block; ALU-level decode is downstream.
REQ-023 illegal_seen SHALL set on a rising clk edge where illegal=1 and SHALL remain set until reset.

Reset
REQ-024 rst=1 SHALL clear illegal_seen to 0 asynchronously.
REQ-025 rst SHALL NOT affect any combinational output.
REQ-026 Reset deasserting on the same edge as illegal=1 SHALL leave illegal_seen 0 until the following edge.

Structure
REQ-027 Opcode, ImmSrc, ALUOp and wb_sel encodings SHALL be constants in the shared defines.vh.
REQ-028 Immediate formation SHALL be one sub-module imm_gen (instr, ImmSrc -> imm).
REQ-029 Field slicing and control decode SHALL be inline in decoder_glue.

Verification
REQ-030 Bench SHALL drive add x5,x1,x2 (0x002082B3) and require rd=5, rs1=1, rs2=2, regWrite=1, ALUSrc=0, ALUOp=10, wb_sel=0, imm=0.
REQ-031 Bench SHALL drive lw x7,24(x3) and require MemRead=1, ALUSrc=1, ALUOp=00, wb_sel=1, imm=24; it SHALL then drive sw x8,28(x4) and require rs1=4, rs2=8, MemWrite=1, regWrite=0, imm=28.
REQ-032 Bench SHALL drive beq x1,x2,+16 and require BranchSig=Branch=1, ALUOp=01, imm=16; it SHALL also drive offset -4 and require imm=0xFFFFFFFC.
REQ-033 Bench SHALL drive jal x1,+32 and require Jump=JAL=1, JALR=0, wb_sel=2, imm=32; it SHALL then drive jalr x5,20(x9) and require JALR=1, JAL=0, imm=20.
REQ-034 Bench SHALL drive lui x10,0x12345 and require ALUOp=11, imm=0x12345000; it SHALL then drive auipc x11,0x01234 and require ALUOp=00, imm=0x01234000.
REQ-035 Bench SHALL drive opcode 0x7F and require illegal=1 with all strobes 0, illegal_seen=1 after one clk, and illegal_seen=0 once rst is pulsed.
